// File: rtl/clip_transport_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clip_transport_ctrl_pkg
// Description : Shared types and constants for the clip transport controller:
//               FSM state encoding, mode output codes, seconds saturation.
// Revision    : 1.0 - initial release
// ============================================================================
package clip_transport_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_PLAY   = 2'd2
   } state_t;

   localparam logic [1:0] c_MODE_IDLE   = 2'b00;
   localparam logic [1:0] c_MODE_RECORD = 2'b01;
   localparam logic [1:0] c_MODE_PLAY   = 2'b10;

   // Seconds display tops out at a single decimal digit
   localparam logic [3:0] c_COUNT_MAX = 4'd9;

   function automatic logic [1:0] mode_of(input state_t st);
      case (st)
         ST_RECORD: mode_of = c_MODE_RECORD;
         ST_PLAY:   mode_of = c_MODE_PLAY;
         default:   mode_of = c_MODE_IDLE;
      endcase
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      sat_inc = (v >= c_COUNT_MAX) ? c_COUNT_MAX : v + 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clip_transport_ctrl_btn_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge_det
// Description : Rising-edge detector for a debounced button level. Edges are
//               suppressed during the first cycle after reset so a button
//               held through reset release does not fire.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge_det (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   logic r_prev;
   logic r_armed;

   // History of the button level plus a one-shot arm flag after reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_prev  <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_prev  <= btn;
         r_armed <= 1'b1;
      end
   end

   assign rise = btn & ~r_prev & r_armed;

endmodule
`default_nettype wire

// File: rtl/clip_transport_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clip_transport_ctrl
// Description : Two-clip record/play transport. Drives clip memory strobes
//               on sample_tick, tracks per-clip lengths and an elapsed
//               seconds counter (0..9) for display.
// Revision    : 1.0 - initial release
// ============================================================================
module clip_transport_ctrl
   import clip_transport_ctrl_pkg::*;
#(
   parameter int ADDR_W          = 16,
   parameter int SAMPLES_PER_SEC = 8000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              btn_record,
   input  logic              btn_play,
   input  logic              btn_stop,
   input  logic              switch0,
   input  logic              switch1,
   input  logic              sample_tick,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W:0]   mem_addr,
   output logic [1:0]        mode,
   output logic              active_clip,
   output logic [3:0]        count
);

   localparam int                c_PW          = (SAMPLES_PER_SEC > 1) ? $clog2(SAMPLES_PER_SEC) : 1;
   localparam logic [c_PW-1:0]   c_PRESC_LAST  = c_PW'(SAMPLES_PER_SEC - 1);
   localparam logic [c_PW-1:0]   c_PRESC_ONE   = c_PW'(1);
   localparam logic [ADDR_W-1:0] c_INDEX_LAST  = '1;
   localparam logic [ADDR_W-1:0] c_INDEX_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W:0]   c_LEN_ONE     = (ADDR_W+1)'(1);

   logic w_rec_edge, w_play_edge, w_stop_edge;

   btn_edge_det u_det_record (.clock(clock), .reset(reset), .btn(btn_record), .rise(w_rec_edge));
   btn_edge_det u_det_play   (.clock(clock), .reset(reset), .btn(btn_play),   .rise(w_play_edge));
   btn_edge_det u_det_stop   (.clock(clock), .reset(reset), .btn(btn_stop),   .rise(w_stop_edge));

   state_t            r_state, w_state_next;
   logic [ADDR_W-1:0] r_index;
   logic [ADDR_W:0]   r_clip_len [2];
   logic [c_PW-1:0]   r_presc;
   logic [3:0]        r_count;
   logic              r_active;
   logic [1:0]        r_mode;

   logic              w_start_rec, w_start_play, w_leave_rec, w_write, w_read;
   logic [ADDR_W:0]   w_play_last;
   logic [ADDR_W:0]   w_len_new;

   assign w_play_last = r_clip_len[r_active] - c_LEN_ONE;
   // Writes performed so far, including a write happening this cycle
   assign w_len_new   = {1'b0, r_index} + (w_write ? c_LEN_ONE : '0);

   // Next-state and per-cycle strobes; stop outranks every other event
   always_comb begin
      w_state_next = r_state;
      w_start_rec  = 1'b0;
      w_start_play = 1'b0;
      w_leave_rec  = 1'b0;
      w_write      = 1'b0;
      w_read       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rec_edge) begin
               w_state_next = ST_RECORD;
               w_start_rec  = 1'b1;
            end else if (w_play_edge && (r_clip_len[switch1] != '0)) begin
               w_state_next = ST_PLAY;
               w_start_play = 1'b1;
            end
         end
         ST_RECORD: begin
            if (w_stop_edge) begin
               w_state_next = ST_IDLE;
               w_leave_rec  = 1'b1;
            end else if (sample_tick) begin
               w_write = 1'b1;
               if (r_index == c_INDEX_LAST) begin
                  w_state_next = ST_IDLE;
                  w_leave_rec  = 1'b1;
               end
            end
         end
         ST_PLAY: begin
            if (w_stop_edge) begin
               w_state_next = ST_IDLE;
            end else if (sample_tick) begin
               w_read = 1'b1;
               if ({1'b0, r_index} == w_play_last) begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State register with registered mode and latched clip select
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_mode   <= c_MODE_IDLE;
         r_active <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_mode  <= mode_of(w_state_next);
         if (w_start_rec) begin
            r_active <= switch0;
         end else if (w_start_play) begin
            r_active <= switch1;
         end
      end
   end

   // Sample index, seconds prescaler/counter and stored clip lengths
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_index       <= '0;
         r_presc       <= '0;
         r_count       <= '0;
         r_clip_len[0] <= '0;
         r_clip_len[1] <= '0;
      end else begin
         if (w_start_rec || w_start_play) begin
            r_index <= '0;
            r_presc <= '0;
            r_count <= '0;
         end else if (w_write || w_read) begin
            // Index parks at the last address instead of wrapping
            if (r_index != c_INDEX_LAST) begin
               r_index <= r_index + c_INDEX_ONE;
            end
            if (r_presc == c_PRESC_LAST) begin
               r_presc <= '0;
               r_count <= sat_inc(r_count);
            end else begin
               r_presc <= r_presc + c_PRESC_ONE;
            end
         end
         if (w_leave_rec) begin
            r_clip_len[r_active] <= w_len_new;
         end
      end
   end

   assign mem_we      = w_write;
   assign mem_re      = w_read;
   assign mem_addr    = {r_active, r_index};
   assign mode        = r_mode;
   assign active_clip = r_active;
   assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_clip_transport_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clip_transport_ctrl
// Description : Directed self-checking bench for clip_transport_ctrl with
//               ADDR_W=3 (8-sample clips) and SAMPLES_PER_SEC=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clip_transport_ctrl;

   localparam int c_ADDR_W = 3;
   localparam int c_SPS    = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              btn_record, btn_play, btn_stop;
   logic              switch0, switch1, sample_tick;
   logic              mem_we, mem_re;
   logic [c_ADDR_W:0] mem_addr;
   logic [1:0]        mode;
   logic              active_clip;
   logic [3:0]        count;

   int n_cmp  = 0;
   int n_fail = 0;

   clip_transport_ctrl #(
      .ADDR_W          (c_ADDR_W),
      .SAMPLES_PER_SEC (c_SPS)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .btn_record  (btn_record),
      .btn_play    (btn_play),
      .btn_stop    (btn_stop),
      .switch0     (switch0),
      .switch1     (switch1),
      .sample_tick (sample_tick),
      .mem_we      (mem_we),
      .mem_re      (mem_re),
      .mem_addr    (mem_addr),
      .mode        (mode),
      .active_clip (active_clip),
      .count       (count)
   );

   always #5 clock = ~clock;

   // Advance to just past the next rising edge
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; btn_record = 1'b1; btn_play = 1'b0; btn_stop = 1'b0;
      switch0 = 1'b0; switch1 = 1'b0; sample_tick = 1'b0;

      // Reset state, with record held through reset release
      cyc(); #1;
      chk("rst_mode",   mode, 0);
      chk("rst_we",     mem_we, 0);
      chk("rst_re",     mem_re, 0);
      chk("rst_addr",   mem_addr, 0);
      chk("rst_active", active_clip, 0);
      chk("rst_count",  count, 0);
      cyc();
      reset = 1'b0;
      cyc(); cyc(); cyc(); #1;
      chk("held_rec_no_event", mode, 0);
      btn_record = 1'b0;
      cyc();

      // Record clip 1 to full
      switch0 = 1'b1; btn_record = 1'b1;
      cyc(); #1;
      chk("t1_mode", mode, 1);
      chk("t1_active", active_clip, 1);
      chk("t1_count0", count, 0);
      btn_record = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sample_tick = 1'b1; #1;
         chk("t1_we", mem_we, 1);
         chk("t1_re", mem_re, 0);
         chk("t1_addr", mem_addr, 8 + i);
         chk("t1_mode_rec", mode, 1);
         cyc();
      end
      sample_tick = 1'b0; #1;
      chk("t1_mode_end", mode, 0);
      chk("t1_count", count, 4);
      chk("t1_we_idle", mem_we, 0);

      // Play clip 1 to end
      switch1 = 1'b1; btn_play = 1'b1;
      cyc(); #1;
      chk("t2_mode", mode, 2);
      chk("t2_active", active_clip, 1);
      chk("t2_count0", count, 0);
      btn_play = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sample_tick = 1'b1; #1;
         chk("t2_re", mem_re, 1);
         chk("t2_we", mem_we, 0);
         chk("t2_addr", mem_addr, 8 + i);
         chk("t2_mode_play", mode, 2);
         cyc();
      end
      sample_tick = 1'b0; #1;
      chk("t2_mode_end", mode, 0);
      chk("t2_count", count, 4);

      // Play of empty clip 0
      switch1 = 1'b0; btn_play = 1'b1; sample_tick = 1'b1; #1;
      chk("t3_re_edge", mem_re, 0);
      cyc(); #1;
      chk("t3_mode", mode, 0);
      chk("t3_re", mem_re, 0);
      chk("t3_count_hold", count, 4);
      btn_play = 1'b0; sample_tick = 1'b0;
      cyc();

      // Record clip 0, stop coincides with the 4th tick
      switch0 = 1'b0; btn_record = 1'b1;
      cyc(); #1;
      chk("t4_mode", mode, 1);
      chk("t4_active", active_clip, 0);
      btn_record = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample_tick = 1'b1; #1;
         chk("t4_we", mem_we, 1);
         chk("t4_addr", mem_addr, i);
         cyc();
      end
      sample_tick = 1'b1; btn_stop = 1'b1; #1;
      chk("t4_we_on_stop", mem_we, 0);
      cyc(); #1;
      chk("t4_mode_end", mode, 0);
      chk("t4_count", count, 1);
      sample_tick = 1'b0; btn_stop = 1'b0;
      cyc();
      // Clip 0 now holds 3 samples
      switch1 = 1'b0; btn_play = 1'b1;
      cyc(); #1;
      chk("t4p_mode", mode, 2);
      chk("t4p_active", active_clip, 0);
      btn_play = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample_tick = 1'b1; #1;
         chk("t4p_re", mem_re, 1);
         chk("t4p_addr", mem_addr, i);
         cyc();
      end
      sample_tick = 1'b0; #1;
      chk("t4p_mode_end", mode, 0);

      // Simultaneous edges, ignored play and switch change in RECORD
      switch0 = 1'b1; btn_record = 1'b1; btn_play = 1'b1;
      cyc(); #1;
      chk("t5_mode", mode, 1);
      chk("t5_active", active_clip, 1);
      btn_record = 1'b0; btn_play = 1'b0;
      cyc();
      btn_play = 1'b1; switch0 = 1'b0;
      cyc(); #1;
      chk("t5_play_ignored", mode, 1);
      chk("t5_switch_ignored", active_clip, 1);
      btn_play = 1'b0; sample_tick = 1'b1; #1;
      chk("t5_we", mem_we, 1);
      chk("t5_addr", mem_addr, 8);
      cyc();
      sample_tick = 1'b0; btn_stop = 1'b1;
      cyc(); #1;
      chk("t5_mode_end", mode, 0);
      btn_stop = 1'b0;
      cyc();

      // Reset mid-PLAY of clip 1 (one sample long)
      switch1 = 1'b1; btn_play = 1'b1;
      cyc(); #1;
      chk("t6_mode", mode, 2);
      chk("t6_active", active_clip, 1);
      sample_tick = 1'b1;
      #1 reset = 1'b1;
      #1;
      chk("t6_rst_mode", mode, 0);
      chk("t6_rst_re", mem_re, 0);
      chk("t6_rst_we", mem_we, 0);
      chk("t6_rst_addr", mem_addr, 0);
      chk("t6_rst_active", active_clip, 0);
      chk("t6_rst_count", count, 0);
      cyc();
      reset = 1'b0; sample_tick = 1'b0;
      cyc(); cyc(); #1;
      chk("t6_held_play", mode, 0);
      btn_play = 1'b0;
      cyc();
      btn_play = 1'b1; switch1 = 1'b1;
      cyc(); #1;
      chk("t6_len1_cleared", mode, 0);
      btn_play = 1'b0;
      cyc();
      btn_play = 1'b1; switch1 = 1'b0;
      cyc(); #1;
      chk("t6_len0_cleared", mode, 0);
      btn_play = 1'b0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clip_transport_ctrl.md
CLIP_TRANSPORT_CTRL -- requirements
Module: clip_transport_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, meaning sample-index width per clip (clip depth 2^ADDR_W samples).
REQ-002 Parameter SAMPLES_PER_SEC, default 8000, meaning sample_tick strobes per displayed second.
REQ-003 clock  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 btn_record  in  1  debounced level, start recording.
REQ-006 btn_play  in  1  debounced level, start playback.
REQ-007 btn_stop  in  1  debounced level, abort current operation.
REQ-008 switch0  in  1  record clip select (0 = clip 0, 1 = clip 1).
REQ-009 switch1  in  1  play clip select (0 = clip 0, 1 = clip 1).
REQ-010 sample_tick  in  1  one-cycle strobe at the audio sample rate.
REQ-011 mem_we  out  1  one-cycle write strobe to clip memory.
REQ-012 mem_re  out  1  one-cycle read strobe to clip memory.
REQ-013 mem_addr  out  ADDR_W+1  {active clip, sample index}.
REQ-014 mode  out  2  00 idle, 01 record, 10 play; 11 never driven.
REQ-015 active_clip  out  1  clip latched for the current operation.
REQ-016 count  out  4  elapsed whole seconds, 0..9, for the 7-segment display.

Function
REQ-017 Button inputs SHALL be rising-edge detected; holding a button SHALL produce exactly one event.
REQ-018 FSM states SHALL be IDLE, RECORD, PLAY.
REQ-019 IDLE + record edge SHALL enter RECORD next cycle, latching switch0 into active_clip, index = 0, count = 0.
REQ-020 IDLE + play edge with clip_len[switch1] != 0 SHALL enter PLAY, latching switch1, index = 0, count = 0; with clip_len = 0 it SHALL stay IDLE.
REQ-021 Simultaneous record and play edges in IDLE SHALL select RECORD.
REQ-022 Stop edge in RECORD or PLAY SHALL return to IDLE next cycle; stop has priority over every other event in that cycle, including sample_tick.
REQ-023 Record or play edges outside IDLE SHALL be ignored; switch changes outside IDLE SHALL be ignored.
REQ-024 In RECORD, each sample_tick SHALL assert mem_we for that cycle with mem_addr = {active_clip, index}, then increment index.
REQ-025 In PLAY, each sample_tick SHALL assert mem_re likewise, then increment index.
REQ-026 mem_we and mem_re SHALL never assert together, and SHALL never assert in IDLE.
REQ-027 On leaving RECORD (stop or full), clip_len[active_clip] SHALL be set to the number of writes performed (ADDR_W+1 bits).
REQ-028 RECORD SHALL end automatically after the write at index 2^ADDR_W-1 (clip_len = 2^ADDR_W); index SHALL not wrap.
REQ-029 PLAY SHALL end automatically after the read at index clip_len-1.
REQ-030 A seconds prescaler SHALL count sample_ticks in RECORD/PLAY; at SAMPLES_PER_SEC it SHALL clear and increment count, saturating at 9.
REQ-031 In IDLE, count SHALL hold its last value until the next operation starts.
REQ-032 mode and active_clip SHALL be registered outputs, updated in the cycle the state changes.

Reset
REQ-033 Reset SHALL force IDLE, mem_we = 0, mem_re = 0, mem_addr = 0, mode = 00, active_clip = 0, count = 0, index = 0, prescaler = 0, both clip_len = 0, and the edge-detect history = 0.
REQ-034 Reset mid-operation SHALL discard the in-progress clip length.
REQ-035 A button held across reset release SHALL not generate an event.

Structure
REQ-036 A shared package SHALL hold the state enum, the mode encodings, and the count saturation constant 9.
REQ-037 A sub-module btn_edge_det SHALL be instantiated three times, once per button.

Verification (ADDR_W=3, SAMPLES_PER_SEC=2)
REQ-038 Test record-to-full: switch0=1, record edge, 8 ticks -> 8 mem_we at addresses 8..15; return to IDLE; clip_len[1]=8; count=4.
REQ-039 Test play-to-end: switch1=1, play edge, 8 ticks -> 8 mem_re at addresses 8..15, mode=10 throughout, then 00.
REQ-040 Test play of an empty clip: switch1=0, play edge -> mode stays 00; no mem_re.
REQ-041 Test stop on a tick: record clip 0, 3 ticks, then stop coincident with the 4th tick -> no 4th mem_we; clip_len[0]=3.
REQ-042 Test simultaneous and ignored events: record and play edges in the same cycle -> mode=01; a play edge during RECORD is ignored; switch0 toggling during RECORD leaves active_clip unchanged.
REQ-043 Test reset mid-PLAY: assert reset asynchronously -> all outputs at reset values immediately; clip_len cleared; a later play edge stays IDLE.
